// File: rtl/fifo_rx_skid_pkg.sv
// -----------------------------------------------------------------------------
// fifo_rx_skid_pkg
// Shared types for the receive-side FIFO drain stage.
//   skid_state_e : occupancy of the 2-entry skid buffer (0, 1 or 2 words)
// -----------------------------------------------------------------------------
package fifo_rx_skid_pkg;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/fifo_rx_skid_beat_counter.sv
// -----------------------------------------------------------------------------
// beat_counter
// Free-running wrap-around counter of accepted output beats.
// Ports:
//   clk   : clock, all logic on posedge
//   rst   : synchronous active-high reset, clears the count
//   inc   : add one to the count this cycle
//   count : current count, wraps modulo 2^CNT_WIDTH
// -----------------------------------------------------------------------------
module beat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  logic [CNT_WIDTH-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (inc) begin
      count_reg <= count_reg + CNT_WIDTH'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/fifo_rx_skid.sv
// -----------------------------------------------------------------------------
// fifo_rx_skid
// Drain stage directly behind the async FIFO read port, receive clock domain.
// Pops words from the FIFO's combinational read port and presents them on a
// registered valid/ready interface through a 2-entry skid buffer (head, tail).
// The pop strobe depends only on registered occupancy, flush and fifo_empty,
// so the consumer's m_ready never reaches the FIFO combinationally.
//
// Ports:
//   clk        : receive-domain clock
//   rst        : synchronous active-high reset, drops buffered words
//   fifo_empty : FIFO empty flag
//   fifo_data  : FIFO read data, valid while fifo_empty=0
//   fifo_pop   : pop strobe to the FIFO (combinational)
//   flush      : discard all buffered words at the next edge
//   m_valid    : output word valid (registered)
//   m_ready    : consumer ready
//   m_data     : output word (registered head entry)
//   xfer_cnt   : accepted-beat count, only when FIFO_RX_SKID_CNT_EN is defined
//
// Build option: define FIFO_RX_SKID_CNT_EN to compile in xfer_cnt and its
// CNT_WIDTH-bit counter; without it the port and counter are absent.
// -----------------------------------------------------------------------------
module fifo_rx_skid
  import fifo_rx_skid_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_pop,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data
`ifdef FIFO_RX_SKID_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  xfer_cnt
`endif
);

  // Reject meaningless widths at elaboration in every build flavour.
  if (DATA_WIDTH < 1 || CNT_WIDTH < 1) begin : g_bad_width
    $error("fifo_rx_skid: DATA_WIDTH and CNT_WIDTH must be at least 1");
  end

  skid_state_e           state_reg, state_next;
  logic [DATA_WIDTH-1:0] head_reg, head_next;
  logic [DATA_WIDTH-1:0] tail_reg, tail_next;
  logic                  push;
  logic                  out;

  // Pop only when a slot is guaranteed free regardless of what the consumer
  // does this cycle; SKID_TWO is the only full state.
  assign fifo_pop = ~rst & ~flush & ~fifo_empty & (state_reg != SKID_TWO);
  assign push     = fifo_pop;
  assign m_valid  = (state_reg != SKID_EMPTY);
  assign m_data   = head_reg;
  assign out      = m_valid & m_ready;

  always_comb begin
    state_next = state_reg;
    head_next  = head_reg;
    tail_next  = tail_reg;
    if (flush) begin
      // Buffered words are discarded; push is already forced low here.
      state_next = SKID_EMPTY;
    end else begin
      case (state_reg)
        SKID_EMPTY: begin
          if (push) begin
            head_next  = fifo_data;
            state_next = SKID_ONE;
          end
        end
        SKID_ONE: begin
          if (push && out) begin
            head_next = fifo_data;
          end else if (push) begin
            tail_next  = fifo_data;
            state_next = SKID_TWO;
          end else if (out) begin
            state_next = SKID_EMPTY;
          end
        end
        SKID_TWO: begin
          if (out) begin
            head_next  = tail_reg;
            state_next = SKID_ONE;
          end
        end
        default: state_next = SKID_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= SKID_EMPTY;
      head_reg  <= '0;
      tail_reg  <= '0;
    end else begin
      state_reg <= state_next;
      head_reg  <= head_next;
      tail_reg  <= tail_next;
    end
  end

`ifdef FIFO_RX_SKID_CNT_EN
  // A beat accepted in a flush cycle still counts; flush does not clear it.
  beat_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_beat_counter (
    .clk  (clk),
    .rst  (rst),
    .inc  (out),
    .count(xfer_cnt)
  );
`endif

endmodule
